time_set_ctrl: RTL and testbench

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

---
 rtl/time_set_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_time_set_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : time_set_ctrl
//  Purpose  : Three-button time/date edit controller with long/short press
//             detection, field wrap with day-of-month clamping and edit timeout.
//  Revision : 1.0
// ============================================================================
module time_set_ctrl #(
    parameter int LONG_CYC    = 2500000,
    parameter int TIMEOUT_CYC = 1000000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        button_mid,
    input  logic        button_up,
    input  logic        button_down,
    input  logic [15:0] cur_year,
    input  logic [7:0]  cur_month,
    input  logic [7:0]  cur_day,
    input  logic [7:0]  cur_hour,
    input  logic [7:0]  cur_minute,
    input  logic [7:0]  cur_sec,
    output logic [15:0] year,
    output logic [7:0]  month,
    output logic [7:0]  day,
    output logic [7:0]  hour,
    output logic [7:0]  minute,
    output logic [7:0]  sec,
    output logic        load,
    output logic        set_active,
    output logic [2:0]  field_sel
);

    localparam int c_lw = $clog2(LONG_CYC + 1);
    localparam int c_tw = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SET_YEAR  = 3'd1,
        SET_MONTH = 3'd2,
        SET_DAY   = 3'd3,
        SET_HOUR  = 3'd4,
        SET_MIN   = 3'd5,
        SET_SEC   = 3'd6,
        COMMIT    = 3'd7
    } state_t;

    state_t          state_q, state_d;
    logic [c_lw-1:0] press_cnt_q, press_cnt_d;
    logic [c_tw-1:0] to_cnt_q, to_cnt_d;
    logic            mid_block_q, mid_block_d;
    logic            up_prev_q, dn_prev_q;
    logic [15:0]     year_q, year_d;
    logic [7:0]      month_q, month_d, day_q, day_d;
    logic [7:0]      hour_q, hour_d, minute_q, minute_d, sec_q, sec_d;
    logic            load_q, load_d, set_active_q, set_active_d;
    logic [2:0]      field_sel_q, field_sel_d;

    function automatic logic [7:0] f_dim(input logic [7:0] m, input logic [15:0] y);
        case (m)
            8'd4, 8'd6, 8'd9, 8'd11: f_dim = 8'd30;
            8'd2:                    f_dim = (y[1:0] == 2'b00) ? 8'd29 : 8'd28;
            default:                 f_dim = 8'd31;
        endcase
    endfunction

    function automatic logic [7:0] f_step8(input logic [7:0] v, input logic [7:0] lo,
                                           input logic [7:0] hi, input logic up);
        if (up) f_step8 = (v >= hi) ? lo : v + 8'd1;
        else    f_step8 = (v <= lo) ? hi : v - 8'd1;
    endfunction

    function automatic logic [15:0] f_step16(input logic [15:0] v, input logic up);
        if (up) f_step16 = (v >= 16'd2099) ? 16'd2000 : v + 16'd1;
        else    f_step16 = (v <= 16'd2000) ? 16'd2099 : v - 16'd1;
    endfunction

    function automatic logic [7:0] f_clamp(input logic [7:0] d, input logic [7:0] lim);
        f_clamp = (d > lim) ? lim : d;
    endfunction

    logic w_long, w_short, w_up_rise, w_dn_rise, w_step_up, w_step_dn;
    logic w_in_set, w_quiet, w_timeout;
    logic [15:0] w_cap_year;
    logic [7:0]  w_cap_month, w_cap_day, w_cap_hour, w_cap_minute, w_cap_sec;

    // Long fires as the count steps to LONG_CYC-1, so every release lands on
    // exactly one of long or short.
    assign w_long    = button_mid && !mid_block_q && (press_cnt_q == c_lw'(LONG_CYC - 2));
    assign w_short   = !button_mid && (press_cnt_q != '0) && (press_cnt_q < c_lw'(LONG_CYC - 1));
    assign w_up_rise = button_up && !up_prev_q;
    assign w_dn_rise = button_down && !dn_prev_q;
    assign w_step_up = w_up_rise && !w_dn_rise;
    assign w_step_dn = w_dn_rise && !w_up_rise;
    assign w_in_set  = (state_q != IDLE) && (state_q != COMMIT);
    assign w_quiet   = !(button_mid || button_up || button_down);
    assign w_timeout = w_in_set && w_quiet && (to_cnt_q >= c_tw'(TIMEOUT_CYC - 1));

    assign w_cap_year   = (cur_year >= 16'd2000 && cur_year <= 16'd2099) ? cur_year : 16'd2000;
    assign w_cap_month  = (cur_month >= 8'd1 && cur_month <= 8'd12) ? cur_month : 8'd1;
    assign w_cap_day    = (cur_day >= 8'd1 && cur_day <= f_dim(w_cap_month, w_cap_year)) ? cur_day : 8'd1;
    assign w_cap_hour   = (cur_hour <= 8'd23) ? cur_hour : 8'd0;
    assign w_cap_minute = (cur_minute <= 8'd59) ? cur_minute : 8'd0;
    assign w_cap_sec    = (cur_sec <= 8'd59) ? cur_sec : 8'd0;

    always_comb begin
        press_cnt_d = '0;
        if (button_mid && !mid_block_q) begin
            press_cnt_d = (press_cnt_q == c_lw'(LONG_CYC)) ? press_cnt_q : press_cnt_q + 1'b1;
        end
        mid_block_d = mid_block_q && button_mid;
        to_cnt_d = '0;
        if (w_in_set && w_quiet) begin
            to_cnt_d = (to_cnt_q == c_tw'(TIMEOUT_CYC)) ? to_cnt_q : to_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (w_long) state_d = SET_YEAR;
            COMMIT: state_d = IDLE;
            default: begin
                if (w_long) begin
                    state_d = IDLE;
                end else if (w_short) begin
                    case (state_q)
                        SET_YEAR:  state_d = SET_MONTH;
                        SET_MONTH: state_d = SET_DAY;
                        SET_DAY:   state_d = SET_HOUR;
                        SET_HOUR:  state_d = SET_MIN;
                        SET_MIN:   state_d = SET_SEC;
                        default:   state_d = COMMIT;
                    endcase
                end else if (w_timeout) begin
                    state_d = IDLE;
                end
            end
        endcase
        load_d       = (state_d == COMMIT);
        set_active_d = (state_d != IDLE) && (state_d != COMMIT);
        field_sel_d  = set_active_d ? state_d : 3'd0;
    end

    always_comb begin
        year_d   = year_q;
        month_d  = month_q;
        day_d    = day_q;
        hour_d   = hour_q;
        minute_d = minute_q;
        sec_d    = sec_q;
        if (state_q == IDLE && w_long) begin
            year_d   = w_cap_year;
            month_d  = w_cap_month;
            day_d    = w_cap_day;
            hour_d   = w_cap_hour;
            minute_d = w_cap_minute;
            sec_d    = w_cap_sec;
        end else if (w_in_set && !w_long && (w_step_up || w_step_dn)) begin
            case (state_q)
                SET_YEAR: begin
                    year_d = f_step16(year_q, w_step_up);
                    day_d  = f_clamp(day_q, f_dim(month_q, year_d));
                end
                SET_MONTH: begin
                    month_d = f_step8(month_q, 8'd1, 8'd12, w_step_up);
                    day_d   = f_clamp(day_q, f_dim(month_d, year_q));
                end
                SET_DAY:  day_d    = f_step8(day_q, 8'd1, f_dim(month_q, year_q), w_step_up);
                SET_HOUR: hour_d   = f_step8(hour_q, 8'd0, 8'd23, w_step_up);
                SET_MIN:  minute_d = f_step8(minute_q, 8'd0, 8'd59, w_step_up);
                default:  sec_d    = f_step8(sec_q, 8'd0, 8'd59, w_step_up);
            endcase
        end
    end

    // Block and previous-level flags come out of reset set, so a button held
    // across reset release is treated as already pressed until let go.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            press_cnt_q  <= '0;
            to_cnt_q     <= '0;
            mid_block_q  <= 1'b1;
            up_prev_q    <= 1'b1;
            dn_prev_q    <= 1'b1;
            year_q       <= 16'd2000;
            month_q      <= 8'd1;
            day_q        <= 8'd1;
            hour_q       <= 8'd0;
            minute_q     <= 8'd0;
            sec_q        <= 8'd0;
            load_q       <= 1'b0;
            set_active_q <= 1'b0;
            field_sel_q  <= 3'd0;
        end else begin
            state_q      <= state_d;
            press_cnt_q  <= press_cnt_d;
            to_cnt_q     <= to_cnt_d;
            mid_block_q  <= mid_block_d;
            up_prev_q    <= button_up;
            dn_prev_q    <= button_down;
            year_q       <= year_d;
            month_q      <= month_d;
            day_q        <= day_d;
            hour_q       <= hour_d;
            minute_q     <= minute_d;
            sec_q        <= sec_d;
            load_q       <= load_d;
            set_active_q <= set_active_d;
            field_sel_q  <= field_sel_d;
        end
    end

    assign year       = year_q;
    assign month      = month_q;
    assign day        = day_q;
    assign hour       = hour_q;
    assign minute     = minute_q;
    assign sec        = sec_q;
    assign load       = load_q;
    assign set_active = set_active_q;
    assign field_sel  = field_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_time_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_time_set_ctrl
//  Purpose  : Scoreboard bench for time_set_ctrl with a field-level model.
//  Revision : 1.0
// ============================================================================
module tb_time_set_ctrl;
    localparam int LONG = 8;
    localparam int TMO  = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mid = 1'b0, up = 1'b0, dn = 1'b0;
    logic [15:0] cy = 16'd2000;
    logic [7:0]  cmo = 8'd1, cd = 8'd1, ch = 8'd0, cmi = 8'd0, cs = 8'd0;
    logic [15:0] year;
    logic [7:0]  month, day, hour, minute, sec;
    logic        load, set_active;
    logic [2:0]  field_sel;

    time_set_ctrl #(.LONG_CYC(LONG), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .button_mid(mid), .button_up(up), .button_down(dn),
        .cur_year(cy), .cur_month(cmo), .cur_day(cd),
        .cur_hour(ch), .cur_minute(cmi), .cur_sec(cs),
        .year(year), .month(month), .day(day), .hour(hour), .minute(minute), .sec(sec),
        .load(load), .set_active(set_active), .field_sel(field_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id; int act; int fsel; int y; int mo; int d; int h; int mi; int s;
    } snap_t;

    snap_t snap_q[$];
    snap_t commit_q[$];
    int total = 0, bad = 0, snap_id = 0;
    // Model: mode 0 = not editing, 1..6 = field being edited
    int m_mode = 0, m_y = 2000, m_mo = 1, m_d = 1, m_h = 0, m_mi = 0, m_s = 0, m_quiet = 0;

    function automatic int dim(int mo, int y);
        if (mo == 2) return (y % 4 == 0) ? 29 : 28;
        if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
        return 31;
    endfunction

    function automatic int wrap(int v, int lo, int span, int delta);
        return lo + (((v - lo + delta) % span) + span) % span;
    endfunction

    function automatic snap_t model_snap();
        snap_t e;
        e.id = snap_id; e.act = (m_mode != 0) ? 1 : 0; e.fsel = m_mode;
        e.y = m_y; e.mo = m_mo; e.d = m_d; e.h = m_h; e.mi = m_mi; e.s = m_s;
        return e;
    endfunction

    task automatic m_reset();
        m_mode = 0; m_y = 2000; m_mo = 1; m_d = 1; m_h = 0; m_mi = 0; m_s = 0; m_quiet = 0;
    endtask

    task automatic m_edit(int delta);
        case (m_mode)
            1: begin m_y = wrap(m_y, 2000, 100, delta); if (m_d > dim(m_mo, m_y)) m_d = dim(m_mo, m_y); end
            2: begin m_mo = wrap(m_mo, 1, 12, delta); if (m_d > dim(m_mo, m_y)) m_d = dim(m_mo, m_y); end
            3: m_d  = wrap(m_d, 1, dim(m_mo, m_y), delta);
            4: m_h  = wrap(m_h, 0, 24, delta);
            5: m_mi = wrap(m_mi, 0, 60, delta);
            6: m_s  = wrap(m_s, 0, 60, delta);
            default: ;
        endcase
    endtask

    task automatic m_capture();
        m_y  = (cy >= 2000 && cy <= 2099) ? int'(cy) : 2000;
        m_mo = (cmo >= 1 && cmo <= 12) ? int'(cmo) : 1;
        m_d  = (cd >= 1 && int'(cd) <= dim(m_mo, m_y)) ? int'(cd) : 1;
        m_h  = (ch <= 23) ? int'(ch) : 0;
        m_mi = (cmi <= 59) ? int'(cmi) : 0;
        m_s  = (cs <= 59) ? int'(cs) : 0;
        m_mode = 1;
    endtask

    task automatic expect_state();
        snap_id++;
        snap_q.push_back(model_snap());
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cur(int y, int mo, int d, int h, int mi, int s);
        cy = 16'(y); cmo = 8'(mo); cd = 8'(d); ch = 8'(h); cmi = 8'(mi); cs = 8'(s);
    endtask

    task automatic act_long();
        if (m_mode == 0) m_capture(); else m_mode = 0;
        mid = 1'b1; repeat (LONG) tick();
        mid = 1'b0; repeat (2) tick();
        m_quiet = 2; expect_state();
    endtask

    // Expected commit is queued before the press so it is ready when load fires.
    task automatic act_short(int n, bit u, bit d);
        if (m_mode != 0) begin
            if (u != d) m_edit(u ? 1 : -1);
            m_mode++;
            if (m_mode == 7) begin
                commit_q.push_back(model_snap());
                m_mode = 0;
            end
        end
        mid = 1'b1; repeat (n) tick();
        mid = 1'b0; up = u; dn = d; tick();
        up = 1'b0; dn = 1'b0; tick();
        m_quiet = 2; expect_state();
    endtask

    task automatic act_updn(bit u, bit d, int k);
        if (m_mode != 0 && u != d) m_edit(u ? 1 : -1);
        up = u; dn = d; repeat (k) tick();
        up = 1'b0; dn = 1'b0; tick();
        m_quiet = 1; expect_state();
    endtask

    task automatic act_idle(int n);
        repeat (n) tick();
        m_quiet += n;
        if (m_mode != 0 && m_quiet >= TMO) m_mode = 0;
        expect_state();
    endtask

    task automatic act_reset_held(bit use_up);
        if (use_up) begin
            if (m_mode != 0) m_edit(1);
            up = 1'b1;
        end else begin
            mid = 1'b1;
        end
        tick();
        rst = 1'b1; #1;
        m_reset(); expect_state();
        tick(); tick();
        rst = 1'b0; repeat (LONG + 4) tick();
        expect_state();
        up = 1'b0; mid = 1'b0; tick(); tick();
        expect_state();
    endtask

    function automatic bit vals_ok(snap_t e);
        return (32'(year) === e.y) && (32'(month) === e.mo) && (32'(day) === e.d) &&
               (32'(hour) === e.h) && (32'(minute) === e.mi) && (32'(sec) === e.s);
    endfunction

    always @(negedge clk) begin
        snap_t e;
        if (load === 1'b1) begin
            total++;
            if (commit_q.size() == 0) begin
                bad++;
                $display("FAIL load_pulse: got load=1 want load=0 (no commit pending)");
            end else begin
                e = commit_q.pop_front();
                if (!vals_ok(e)) begin
                    bad++;
                    $display("FAIL commit_vals: got %0d/%0d/%0d %0d:%0d:%0d want %0d/%0d/%0d %0d:%0d:%0d",
                             year, month, day, hour, minute, sec, e.y, e.mo, e.d, e.h, e.mi, e.s);
                end
            end
        end
        while (snap_q.size() != 0) begin
            e = snap_q.pop_front();
            total++;
            if (!vals_ok(e) || (32'(set_active) !== e.act) || (32'(field_sel) !== e.fsel)) begin
                bad++;
                $display("FAIL snap%0d: got act=%0d sel=%0d %0d/%0d/%0d %0d:%0d:%0d want act=%0d sel=%0d %0d/%0d/%0d %0d:%0d:%0d",
                         e.id, set_active, field_sel, year, month, day, hour, minute, sec,
                         e.act, e.fsel, e.y, e.mo, e.d, e.h, e.mi, e.s);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        repeat (2) tick();
        m_reset(); expect_state();
        rst = 1'b0; tick();

        // Capture, then a full walk to commit with values untouched
        set_cur(2023, 2, 15, 10, 20, 30);
        act_long();
        repeat (6) act_short(2, 1'b0, 1'b0);

        // Leap-year day clamp when the year steps down
        set_cur(2024, 2, 29, 5, 6, 7);
        act_long();
        act_updn(1'b0, 1'b1, 1);
        act_long();

        // Month wrap downward and minute wrap upward
        set_cur(2023, 1, 10, 10, 59, 30);
        act_long();
        act_short(3, 1'b0, 1'b0);
        act_updn(1'b0, 1'b1, 2);
        repeat (3) act_short(1, 1'b0, 1'b0);
        act_updn(1'b1, 1'b0, 3);
        act_updn(1'b1, 1'b1, 2);
        act_short(4, 1'b1, 1'b0);
        act_long();

        // Timeout and long-press abort from SET_HOUR
        set_cur(2050, 13, 40, 30, 70, 80);
        act_long();
        repeat (3) act_short(2, 1'b0, 1'b0);
        act_idle(58);
        act_idle(8);
        act_long();
        repeat (3) act_short(2, 1'b0, 1'b0);
        act_long();

        // Reset mid-edit with a held button, then held mid across reset
        set_cur(2031, 4, 30, 1, 2, 3);
        act_long();
        repeat (2) act_short(1, 1'b0, 1'b0);
        act_reset_held(1'b1);
        act_updn(1'b1, 1'b0, 1);
        act_long();
        act_reset_held(1'b0);
        act_long();
        act_updn(1'b1, 1'b0, 1);

        for (int i = 0; i < 250; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                set_cur($urandom_range(1995, 2104), $urandom_range(0, 13), $urandom_range(0, 32),
                        $urandom_range(0, 25), $urandom_range(0, 61), $urandom_range(0, 61));
                act_long();
            end else if (sel <= 4) begin
                act_short($urandom_range(1, LONG - 2), ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
            end else if (sel <= 8) begin
                int r;
                r = $urandom_range(0, 4);
                act_updn((r < 2) || (r == 4), (r >= 2), $urandom_range(1, 3));
            end else if (m_quiet < 40) begin
                act_idle($urandom_range(1, 5));
            end else begin
                act_updn(1'b1, 1'b0, 1);
            end
        end

        repeat (4) tick();
        total++;
        if (commit_q.size() != 0) begin
            bad++;
            $display("FAIL commit_drain: got %0d pending commits want 0", commit_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
